fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, width of PC fields.
REQ-002 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, at least 2.
REQ-003 Parameter NOP, default 32'h00000013, instruction presented when the queue is empty.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 f_valid_i  input  1  fetch offers an entry.
REQ-007 f_ready_o  output  1  queue can accept an entry.
REQ-008 f_pc_i  input  XLEN  PC of offered instruction.
REQ-009 f_instr_i  input  32  offered instruction word.
REQ-010 d_valid_o  output  1  head entry valid for decode.
REQ-011 d_ready_i  input  1  decode consumes head this cycle.
REQ-012 d_pc_o  output  XLEN  PC of head entry.
REQ-013 d_pc_next_o  output  XLEN  d_pc_o + 4.
REQ-014 d_instr_o  output  32  instruction of head entry.
REQ-015 flush_i  input  1  branch/jump redirect; discard all entries.
REQ-016 count_o  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-017 Push SHALL occur when f_valid_i and f_ready_o are high at a rising edge and flush_i is low.
REQ-018 Pop SHALL occur when d_valid_o and d_ready_i are high at a rising edge and flush_i is low.
REQ-019 f_ready_o SHALL equal (count_o != DEPTH); it is combinational from state only and does not depend on d_ready_i.
REQ-020 d_valid_o SHALL equal (count_o != 0).
REQ-021 There is no empty bypass: an entry pushed at edge N is first visible on d_* after edge N, so latency is one cycle.
REQ-022 Ordering SHALL be strict FIFO; read and write pointers wrap modulo DEPTH.
REQ-023 Simultaneous push and pop SHALL leave count_o unchanged; the head advances and the new entry is written at the tail.
REQ-024 When full, push is blocked even if a pop occurs in the same cycle; only count_o decrements.
REQ-025 When empty, d_instr_o SHALL be NOP, d_pc_o SHALL be 0, d_pc_next_o SHALL be 4, and d_ready_i is ignored.
REQ-026 flush_i high at an edge SHALL set count_o to 0, reset both pointers, and drop any same-cycle push or pop.
REQ-027 d_pc_next_o SHALL be computed modulo 2^XLEN, so a head PC of all-ones-minus-3 yields 0.
REQ-028 count_o SHALL be updated by +1 on push only, -1 on pop only, and be unchanged on both or neither.
REQ-029 Storage SHALL be registers with no combinational path from f_* inputs to d_* outputs.

Reset
REQ-030 When rst is low, count_o=0, pointers=0, d_valid_o=0, f_ready_o=1, d_instr_o=NOP, d_pc_o=0, and d_pc_next_o=4, asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately; operation resumes at the first edge after rst rises.
REQ-032 Entry storage contents need no reset; outputs SHALL be masked by d_valid_o.

Verification
REQ-033 Reset then push PC=0x0/0x00500093 with d_ready_i=0: the next cycle shows d_valid_o=1, d_pc_o=0x0, d_pc_next_o=0x4, d_instr_o=0x00500093, count_o=1.
REQ-034 Push PCs 0x0, 0x4, 0x8, 0xC with d_ready_i=0: count_o=4 and f_ready_o=0; a fifth push is held off; draining then yields 0x0, 0x4, 0x8, 0xC in order.
REQ-035 Full queue with d_ready_i=1 and f_valid_i=1 for one cycle: count_o=3 and the new PC is not stored; the next cycle's push succeeds.
REQ-036 Two entries queued, then flush_i=1 with f_valid_i=1 (PC=0x40): count_o=0 and d_instr_o=0x00000013; the next push of 0x40 appears with 1-cycle latency.
REQ-037 Continuous push and pop for 10 cycles at count_o=2: count_o stays 2, the pointers wrap at least twice, and ordering is preserved.
REQ-038 Drop rst mid-stream with 3 entries queued: d_valid_o=0 and count_o=0 without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: a register-based FIFO of {pc, instr} pairs between fetch and decode.
// The head is presented to decode one cycle after it is pushed, and flush discards everything.
module fetch_queue #(
    parameter int          XLEN  = 32,
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_valid_i,
    output logic                     f_ready_o,
    input  logic [XLEN-1:0]          f_pc_i,
    input  logic [31:0]              f_instr_i,
    output logic                     d_valid_o,
    input  logic                     d_ready_i,
    output logic [XLEN-1:0]          d_pc_o,
    output logic [XLEN-1:0]          d_pc_next_o,
    output logic [31:0]              d_instr_o,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];

    logic            push;
    logic            pop;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high and flush_i is low; ready never depends on the partner's valid
    // or ready, so a full queue refuses a push even while decode is popping.
    assign f_ready_o = (count_q != CW'(DEPTH));
    assign d_valid_o = (count_q != '0);

    assign push = f_valid_i && f_ready_o && !flush_i;
    assign pop  = d_valid_o && d_ready_i && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; stale contents are hidden by the d_valid_o mask below.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= f_pc_i;
            instr_mem_q[wr_ptr_q] <= f_instr_i;
        end
    end

    assign d_pc_o      = d_valid_o ? pc_mem_q[rd_ptr_q]    : '0;
    assign d_instr_o   = d_valid_o ? instr_mem_q[rd_ptr_q] : NOP;
    assign d_pc_next_o = d_pc_o + XLEN'(4);
    assign count_o     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: reset, latency, full/empty limits,
// flush, steady-state streaming with pointer wrap, PC+4 overflow and async reset.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        f_valid_i;
    logic        f_ready_o;
    logic [31:0] f_pc_i;
    logic [31:0] f_instr_i;
    logic        d_valid_o;
    logic        d_ready_i;
    logic [31:0] d_pc_o;
    logic [31:0] d_pc_next_o;
    logic [31:0] d_instr_o;
    logic        flush_i;
    logic [2:0]  count_o;

    int tests_run;
    int tests_failed;

    logic [31:0] exp_q[$];

    fetch_queue #(
        .XLEN (32),
        .DEPTH(4),
        .NOP  (32'h00000013)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .f_valid_i  (f_valid_i),
        .f_ready_o  (f_ready_o),
        .f_pc_i     (f_pc_i),
        .f_instr_i  (f_instr_i),
        .d_valid_o  (d_valid_o),
        .d_ready_i  (d_ready_i),
        .d_pc_o     (d_pc_o),
        .d_pc_next_o(d_pc_next_o),
        .d_instr_o  (d_instr_o),
        .flush_i    (flush_i),
        .count_o    (count_o)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs and checks happen 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        f_valid_i = 1'b1;
        f_pc_i    = pc;
        f_instr_i = instr;
        step();
        f_valid_i = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check_eq({tag, "_pc"}, d_pc_o, pc);
        check_eq({tag, "_instr"}, d_instr_o, instr);
        d_ready_i = 1'b1;
        step();
        d_ready_i = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b0;
        f_valid_i = 1'b0;
        f_pc_i    = '0;
        f_instr_i = '0;
        d_ready_i = 1'b0;
        flush_i   = 1'b0;
        #1;
        check_eq("rst_count", count_o, 0);
        check_eq("rst_dvalid", d_valid_o, 0);
        check_eq("rst_fready", f_ready_o, 1);
        check_eq("rst_instr", d_instr_o, 32'h00000013);
        check_eq("rst_pc", d_pc_o, 0);
        check_eq("rst_pcnext", d_pc_next_o, 4);
        #2 rst = 1'b1;
        step();

        // Empty queue ignores d_ready_i
        d_ready_i = 1'b1;
        step();
        d_ready_i = 1'b0;
        check_eq("empty_pop_count", count_o, 0);

        // Single push, one-cycle latency, no bypass
        f_valid_i = 1'b1;
        f_pc_i    = 32'h0;
        f_instr_i = 32'h00500093;
        #1;
        check_eq("no_bypass_dvalid", d_valid_o, 0);
        step();
        f_valid_i = 1'b0;
        check_eq("lat_dvalid", d_valid_o, 1);
        check_eq("lat_pc", d_pc_o, 32'h0);
        check_eq("lat_pcnext", d_pc_next_o, 32'h4);
        check_eq("lat_instr", d_instr_o, 32'h00500093);
        check_eq("lat_count", count_o, 1);
        pop_check("lat_drain", 32'h0, 32'h00500093);
        check_eq("lat_drain_count", count_o, 0);

        // Fill to full, held-off fifth push, ordered drain
        for (int i = 0; i < 4; i++) push(32'(4 * i), 32'hA000 + 32'(i));
        check_eq("full_count", count_o, 4);
        check_eq("full_fready", f_ready_o, 0);
        push(32'h10, 32'hBEEF);
        check_eq("full_hold_count", count_o, 4);
        pop_check("drain0", 32'h0, 32'hA000);
        pop_check("drain1", 32'h4, 32'hA001);
        pop_check("drain2", 32'h8, 32'hA002);
        pop_check("drain3", 32'hC, 32'hA003);
        check_eq("drain_count", count_o, 0);
        check_eq("drain_dvalid", d_valid_o, 0);

        // Full queue, pop and blocked push in the same cycle
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'hC000 + 32'(i));
        f_valid_i = 1'b1;
        f_pc_i    = 32'h200;
        f_instr_i = 32'hD000;
        d_ready_i = 1'b1;
        step();
        d_ready_i = 1'b0;
        check_eq("fullpop_count", count_o, 3);
        check_eq("fullpop_head", d_pc_o, 32'h104);
        step();
        f_valid_i = 1'b0;
        check_eq("fullpop_repush_count", count_o, 4);
        pop_check("fp0", 32'h104, 32'hC001);
        pop_check("fp1", 32'h108, 32'hC002);
        pop_check("fp2", 32'h10C, 32'hC003);
        pop_check("fp3", 32'h200, 32'hD000);
        check_eq("fp_count", count_o, 0);

        // Flush drops queued entries and the same-cycle push
        push(32'h20, 32'hE000);
        push(32'h24, 32'hE001);
        flush_i   = 1'b1;
        f_valid_i = 1'b1;
        f_pc_i    = 32'h40;
        f_instr_i = 32'hF000;
        d_ready_i = 1'b1;
        step();
        flush_i   = 1'b0;
        f_valid_i = 1'b0;
        d_ready_i = 1'b0;
        check_eq("flush_count", count_o, 0);
        check_eq("flush_instr", d_instr_o, 32'h00000013);
        check_eq("flush_pcnext", d_pc_next_o, 32'h4);
        push(32'h40, 32'hF000);
        check_eq("postflush_count", count_o, 1);
        pop_check("postflush", 32'h40, 32'hF000);

        // Streaming at occupancy 2: pointers wrap several times
        exp_q.delete();
        push(32'h300, 32'h300);
        exp_q.push_back(32'h300);
        push(32'h304, 32'h304);
        exp_q.push_back(32'h304);
        for (int k = 0; k < 10; k++) begin
            f_valid_i = 1'b1;
            f_pc_i    = 32'h308 + 32'(4 * k);
            f_instr_i = f_pc_i;
            d_ready_i = 1'b1;
            check_eq("stream_pc", d_pc_o, exp_q[0]);
            check_eq("stream_count", count_o, 2);
            exp_q.push_back(f_pc_i);
            void'(exp_q.pop_front());
            step();
        end
        f_valid_i = 1'b0;
        d_ready_i = 1'b0;
        check_eq("stream_end_count", count_o, 2);
        pop_check("stream_tail0", exp_q[0], exp_q[0]);
        pop_check("stream_tail1", exp_q[1], exp_q[1]);
        check_eq("stream_empty", count_o, 0);

        // PC+4 wraps modulo 2^32
        push(32'hFFFFFFFC, 32'h1234);
        check_eq("wrap_pcnext", d_pc_next_o, 32'h0);
        pop_check("wrap", 32'hFFFFFFFC, 32'h1234);

        // Async reset mid-stream
        push(32'h500, 32'h1);
        push(32'h504, 32'h2);
        push(32'h508, 32'h3);
        check_eq("pre_arst_count", count_o, 3);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_dvalid", d_valid_o, 0);
        check_eq("arst_count", count_o, 0);
        check_eq("arst_fready", f_ready_o, 1);
        check_eq("arst_instr", d_instr_o, 32'h00000013);
        #1 rst = 1'b1;
        step();
        check_eq("post_arst_count", count_o, 0);
        push(32'h600, 32'h77);
        check_eq("resume_count", count_o, 1);
        pop_check("resume", 32'h600, 32'h77);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
